ex_pipe_slice: RTL and testbench
================================

Name: ex_pipe_slice

Overview:
- Execute-stage slice of the 5-stage pipelined processor: the ID/EX pipeline register, the combinational execution unit, and the EX/MEM pipeline register.
- Takes the decoded control/operand word from the decode stage.
- Registers it, computes the ALU result and the memory address, then registers the control bits, result and address for the memory stage.
- Input-to-output latency is two clock edges.

Parameters:
- DATA_W, 16, operand width. Input word is 5+2*DATA_W bits; output word is 3+4*DATA_W bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_ex_in  in  5+2*DATA_W (37)  {WB, MW, MR, ALU, ALUOp, Data1[15:0], Data2[15:0]}, MSB first.
- stall  in  1  when 1, both pipeline registers hold their contents.
- flush  in  1  when 1 (and stall=0), ID/EX loads all-zero (bubble) instead of id_ex_in.
- id_ex_q  out  37  current ID/EX register contents, for debug/monitor.
- ex_mem_q  out  3+4*DATA_W (67)  {WB, MW, MR, DataOut[31:0], Address[31:0]}, MSB first.

Behaviour:
- Reset (rst_n=0, asynchronous): id_ex_q=0 and ex_mem_q=0 immediately. Both stay 0 while rst_n is low. First capture is on the first rising edge after release.
- ID/EX register, per rising edge:
  - stall=1: hold.
  - else flush=1: load 0.
  - else: load id_ex_in.
- Execution unit (combinational, from id_ex_q):
  - ALU=1, ALUOp=0: DataOut = zero-extended Data1 + Data2 (17-bit sum, carry kept in bit 16, upper bits 0).
  - ALU=1, ALUOp=1: DataOut = Data1 * Data2, unsigned full 32-bit product.
  - ALU=0: DataOut = zero-extended Data2 (store/pass data). ALUOp is ignored.
  - Address = zero-extended Data1 in all cases.
- EX/MEM register, per rising edge:
  - stall=1: hold.
  - else: load {WB, MW, MR, DataOut, Address} from id_ex_q and the execution unit.
  - flush does not affect EX/MEM directly. A bubble reaches it one cycle later as all-zero.
- Control passthrough: WB, MW and MR are copied unmodified into ex_mem_q[66:64]. No decoding of them inside the block; MW=MR=1 is passed as-is.
- Latency:
  - id_ex_in sampled at edge N appears on id_ex_q after edge N.
  - The corresponding result appears on ex_mem_q after edge N+1.
  - Throughput is one word per cycle.
- Simultaneous stall and flush: stall wins (hold).
- No overflow detection in the base block; sums and products never truncate within 32 bits.

Optional Feature:
- Macro EX_FLAGS_EN. When defined, add output ex_flags_q [1:0] = {Z, C}, registered in EX/MEM alongside ex_mem_q. It resets to 0 and obeys stall.
  - Z = (DataOut == 0).
  - C = DataOut[16] for add. For multiply and pass-through, C = 0.
- When not defined, the port does not exist and no flag logic is generated.

Test Plan:
- Reset: assert rst_n=0 mid-stream, with a nonzero value in both stages -> id_ex_q=0 and ex_mem_q=0 immediately, without waiting for a clock edge.
- Add: id_ex_in={5'b10010, 16'd11, 16'd15} -> after 2 edges, ex_mem_q={3'b100, 32'd26, 32'd11}.
- Multiply: {5'b10011, 16'd11, 16'd15} -> {3'b100, 32'd165, 32'd11}. Also cover 16'hFFFF*16'hFFFF -> DataOut=32'hFFFE0001.
- Pass/bubble and memory controls:
  - {5'b00000, 16'd11, 16'd15} -> {3'b000, 32'd15, 32'd11}.
  - {5'b10100, ...} -> MR=1, DataOut=15, Address=11.
  - {5'b11000, ...} -> MW=1, DataOut=15, Address=11.
- Back-to-back: apply the five words above on consecutive edges -> outputs emerge in order, one per cycle, each 2 edges after its input. Add carry case: 16'hFFFF+16'd1 -> DataOut=32'h00010000 (C=1 with EX_FLAGS_EN).
- Stall/flush:
  - stall=1 for 2 cycles -> id_ex_q and ex_mem_q frozen.
  - flush=1 for 1 cycle -> ex_mem_q becomes all-zero one edge later.
  - stall and flush together -> hold.

Source files
------------

// File: rtl/ex_pipe_slice_if.sv
// ----------------------------------------------------------------------------
// ex_pipe_slice_if
//
// Purpose: bundles the execute-stage slice's datapath and pipeline-control
// signals so that the decode side and the slice share one declaration.
//
// Optional feature: when the macro EX_FLAGS_EN is defined, the interface also
// carries ex_flags_q = {Z, C}, registered alongside ex_mem_q.
//
// Signals (DATA_W = operand width):
//   id_ex_in   [5+2*DATA_W-1:0]  {WB, MW, MR, ALU, ALUOp, Data1, Data2}
//   stall                        1 = both pipeline registers hold
//   flush                        1 (with stall = 0) = ID/EX loads a bubble
//   id_ex_q    [5+2*DATA_W-1:0]  current ID/EX register contents
//   ex_mem_q   [3+4*DATA_W-1:0]  {WB, MW, MR, DataOut, Address}
//   ex_flags_q [1:0]             {Z, C}   (EX_FLAGS_EN only)
//
// Pipeline control: there is no valid/ready handshake. Every rising edge
// advances the pipe by one word unless stall is high, in which case both
// registers hold. flush replaces the incoming word with all-zero, and stall
// takes priority over flush.
//
// Modports:
//   master - decode/testbench side: drives id_ex_in, stall, flush
//   slave  - the slice itself: drives id_ex_q, ex_mem_q (and ex_flags_q)
// ----------------------------------------------------------------------------
interface ex_pipe_slice_if #(
    parameter int DATA_W = 16
);
    logic [5+2*DATA_W-1:0] id_ex_in;
    logic                  stall;
    logic                  flush;
    logic [5+2*DATA_W-1:0] id_ex_q;
    logic [3+4*DATA_W-1:0] ex_mem_q;
`ifdef EX_FLAGS_EN
    logic [1:0]            ex_flags_q;
`endif

`ifdef EX_FLAGS_EN
    modport master (
        output id_ex_in,
        output stall,
        output flush,
        input  id_ex_q,
        input  ex_mem_q,
        input  ex_flags_q
    );

    modport slave (
        input  id_ex_in,
        input  stall,
        input  flush,
        output id_ex_q,
        output ex_mem_q,
        output ex_flags_q
    );
`else
    modport master (
        output id_ex_in,
        output stall,
        output flush,
        input  id_ex_q,
        input  ex_mem_q
    );

    modport slave (
        input  id_ex_in,
        input  stall,
        input  flush,
        output id_ex_q,
        output ex_mem_q
    );
`endif

endinterface : ex_pipe_slice_if

// File: rtl/ex_pipe_slice.sv
// ----------------------------------------------------------------------------
// ex_pipe_slice
//
// Purpose: execute-stage slice of a 5-stage pipeline. It holds the ID/EX
// pipeline register, the combinational execution unit (add / multiply /
// pass-through plus address generation) and the EX/MEM pipeline register.
// A word sampled on edge N is visible on id_ex_q after edge N and its result
// on ex_mem_q after edge N+1; throughput is one word per cycle.
//
// Optional feature: macro EX_FLAGS_EN adds the registered {Z, C} flags on
// bus.ex_flags_q. Without the macro no flag logic exists.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, clears both registers
//   bus    ex_pipe_slice_if.slave
//            id_ex_in  in   {WB, MW, MR, ALU, ALUOp, Data1, Data2}
//            stall     in   hold both registers
//            flush     in   load a bubble into ID/EX (stall wins)
//            id_ex_q   out  ID/EX contents
//            ex_mem_q  out  {WB, MW, MR, DataOut[2*DATA_W-1:0],
//                            Address[2*DATA_W-1:0]}
//            ex_flags_q out {Z, C}  (EX_FLAGS_EN only)
//
// The module parameter DATA_W must match the one of the connected interface.
// ----------------------------------------------------------------------------
module ex_pipe_slice #(
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    ex_pipe_slice_if.slave bus
);

    localparam int IN_W  = 5 + 2 * DATA_W;
    localparam int OUT_W = 3 + 4 * DATA_W;
    localparam int RES_W = 2 * DATA_W;

    // ------------------------------------------------------------------
    // ID/EX pipeline register
    // ------------------------------------------------------------------
    logic [IN_W-1:0] id_ex_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_r <= '0;
        end else if (bus.stall) begin
            id_ex_r <= id_ex_r;
        end else if (bus.flush) begin
            // A bubble is the all-zero word: no write-back, no memory access.
            id_ex_r <= '0;
        end else begin
            id_ex_r <= bus.id_ex_in;
        end
    end

    assign bus.id_ex_q = id_ex_r;

    // ------------------------------------------------------------------
    // Field extraction from the ID/EX word (MSB first)
    // ------------------------------------------------------------------
    logic              ctl_wb;
    logic              ctl_mw;
    logic              ctl_mr;
    logic              ctl_alu;
    logic              ctl_alu_op;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;

    assign ctl_wb     = id_ex_r[IN_W-1];
    assign ctl_mw     = id_ex_r[IN_W-2];
    assign ctl_mr     = id_ex_r[IN_W-3];
    assign ctl_alu    = id_ex_r[IN_W-4];
    assign ctl_alu_op = id_ex_r[IN_W-5];
    assign data1      = id_ex_r[2*DATA_W-1:DATA_W];
    assign data2      = id_ex_r[DATA_W-1:0];

    // ------------------------------------------------------------------
    // Execution unit
    // ------------------------------------------------------------------
    // The sum keeps its carry in bit DATA_W; the product is computed at
    // full double width so neither result is ever truncated.
    logic [DATA_W:0]  sum;
    logic [RES_W-1:0] product;
    logic [RES_W-1:0] data_out;
    logic [RES_W-1:0] address;

    assign sum     = {1'b0, data1} + {1'b0, data2};
    assign product = {{DATA_W{1'b0}}, data1} * {{DATA_W{1'b0}}, data2};
    assign address = {{DATA_W{1'b0}}, data1};

    always_comb begin
        data_out = '0;
        if (ctl_alu) begin
            if (ctl_alu_op) begin
                data_out = product;
            end else begin
                data_out = {{(DATA_W-1){1'b0}}, sum};
            end
        end else begin
            // Store / pass-through: ALUOp is a don't-care here.
            data_out = {{DATA_W{1'b0}}, data2};
        end
    end

    // ------------------------------------------------------------------
    // EX/MEM pipeline register
    // ------------------------------------------------------------------
    // flush has no direct effect here; a bubble arrives one edge later
    // through id_ex_r as an all-zero word.
    logic [OUT_W-1:0] ex_mem_r;
    logic [OUT_W-1:0] ex_mem_next;

    // WB/MW/MR are forwarded untouched, including the MW=MR=1 combination.
    assign ex_mem_next = {ctl_wb, ctl_mw, ctl_mr, data_out, address};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem_r <= '0;
        end else if (bus.stall) begin
            ex_mem_r <= ex_mem_r;
        end else begin
            ex_mem_r <= ex_mem_next;
        end
    end

    assign bus.ex_mem_q = ex_mem_r;

`ifdef EX_FLAGS_EN
    // ------------------------------------------------------------------
    // Result flags {Z, C}, registered with the EX/MEM word
    // ------------------------------------------------------------------
    logic       flag_z;
    logic       flag_c;
    logic [1:0] flags_r;

    assign flag_z = (data_out == '0);
    // Carry is meaningful only for the add operation.
    assign flag_c = ctl_alu && !ctl_alu_op && sum[DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r <= 2'b00;
        end else if (bus.stall) begin
            flags_r <= flags_r;
        end else begin
            flags_r <= {flag_z, flag_c};
        end
    end

    assign bus.ex_flags_q = flags_r;
`endif

endmodule : ex_pipe_slice

// File: tb/tb_ex_pipe_slice.sv
// ----------------------------------------------------------------------------
// tb_ex_pipe_slice
//
// Directed bench for ex_pipe_slice (DATA_W = 16). Expected words are
// hand-computed constants. With EX_FLAGS_EN defined the {Z, C} flags are
// checked as well.
// ----------------------------------------------------------------------------
module tb_ex_pipe_slice;

    localparam int DATA_W = 16;
    localparam int IN_W   = 5 + 2 * DATA_W;
    localparam int OUT_W  = 3 + 4 * DATA_W;
    localparam int NVEC   = 9;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ex_pipe_slice_if #(.DATA_W(DATA_W)) bus ();

    ex_pipe_slice #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    int total;
    int bad;

    // ------------------------------------------------------------------
    // Directed vectors: inputs, expected EX/MEM word, expected {Z, C}
    // ------------------------------------------------------------------
    logic [IN_W-1:0]  vin  [NVEC];
    logic [OUT_W-1:0] vexp [NVEC];
    logic [1:0]       vflg [NVEC];

    initial begin
        // add 11 + 15
        vin[0] = {5'b10010, 16'd11, 16'd15};     vexp[0] = {3'b100, 32'd26, 32'd11};          vflg[0] = 2'b00;
        // multiply 11 * 15
        vin[1] = {5'b10011, 16'd11, 16'd15};     vexp[1] = {3'b100, 32'd165, 32'd11};         vflg[1] = 2'b00;
        // pass / bubble-like controls
        vin[2] = {5'b00000, 16'd11, 16'd15};     vexp[2] = {3'b000, 32'd15, 32'd11};          vflg[2] = 2'b00;
        // memory read
        vin[3] = {5'b10100, 16'd11, 16'd15};     vexp[3] = {3'b101, 32'd15, 32'd11};          vflg[3] = 2'b00;
        // memory write
        vin[4] = {5'b11000, 16'd11, 16'd15};     vexp[4] = {3'b110, 32'd15, 32'd11};          vflg[4] = 2'b00;
        // add with carry out: FFFF + 1
        vin[5] = {5'b10010, 16'hFFFF, 16'h0001}; vexp[5] = {3'b100, 32'h0001_0000, 32'h0000_FFFF}; vflg[5] = 2'b01;
        // largest product: FFFF * FFFF
        vin[6] = {5'b10011, 16'hFFFF, 16'hFFFF}; vexp[6] = {3'b100, 32'hFFFE_0001, 32'h0000_FFFF}; vflg[6] = 2'b00;
        // pass with ALUOp set (ignored), MW=MR=1 forwarded as-is
        vin[7] = {5'b01101, 16'd3, 16'd4};       vexp[7] = {3'b011, 32'd4, 32'd3};            vflg[7] = 2'b00;
        // add giving zero result
        vin[8] = {5'b10010, 16'd0, 16'd0};       vexp[8] = {3'b100, 32'd0, 32'd0};            vflg[8] = 2'b10;
    end

    // ------------------------------------------------------------------
    // Driver / checker tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [IN_W-1:0] word, input logic st, input logic fl);
        bus.id_ex_in = word;
        bus.stall    = st;
        bus.flush    = fl;
    endtask

    task automatic check_id(input string tag, input logic [IN_W-1:0] expv);
        total++;
        assert (bus.id_ex_q === expv) else begin
            bad++;
            $error("FAIL %s id_ex_q observed=%h expected=%h", tag, bus.id_ex_q, expv);
        end
    endtask

    task automatic check_mem(input string tag, input logic [OUT_W-1:0] expv);
        total++;
        assert (bus.ex_mem_q === expv) else begin
            bad++;
            $error("FAIL %s ex_mem_q observed=%h expected=%h", tag, bus.ex_mem_q, expv);
        end
    endtask

    task automatic check_flags(input string tag, input logic [1:0] expv);
`ifdef EX_FLAGS_EN
        total++;
        assert (bus.ex_flags_q === expv) else begin
            bad++;
            $error("FAIL %s ex_flags_q observed=%b expected=%b", tag, bus.ex_flags_q, expv);
        end
`else
        if (expv === 2'bxx) $display("unused %s", tag);
`endif
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive('0, 1'b0, 1'b0);

        // Reset state, including across clock edges while held low
        #1;
        check_id("reset_id", '0);
        check_mem("reset_mem", '0);
        check_flags("reset_flags", 2'b00);
        drive(vin[0], 1'b0, 1'b0);
        tick();
        tick();
        check_id("reset_hold_id", '0);
        check_mem("reset_hold_mem", '0);
        #2;
        rst_n = 1'b1;

        // Back-to-back stream: each word on id_ex_q after one edge,
        // its result on ex_mem_q after the next.
        for (int i = 0; i < NVEC; i++) begin
            drive(vin[i], 1'b0, 1'b0);
            tick();
            check_id($sformatf("stream_id_%0d", i), vin[i]);
            if (i > 0) begin
                check_mem($sformatf("stream_mem_%0d", i - 1), vexp[i-1]);
                check_flags($sformatf("stream_flags_%0d", i - 1), vflg[i-1]);
            end
        end
        drive('0, 1'b0, 1'b0);
        tick();
        check_mem("stream_mem_last", vexp[NVEC-1]);
        check_flags("stream_flags_last", vflg[NVEC-1]);

        // Preload: id_ex = add, ex_mem = carry case result
        drive(vin[5], 1'b0, 1'b0);
        tick();
        drive(vin[0], 1'b0, 1'b0);
        tick();
        check_id("preload_id", vin[0]);
        check_mem("preload_mem", vexp[5]);

        // Stall for two cycles: both registers frozen
        drive(vin[1], 1'b1, 1'b0);
        tick();
        check_id("stall1_id", vin[0]);
        check_mem("stall1_mem", vexp[5]);
        check_flags("stall1_flags", vflg[5]);
        tick();
        check_id("stall2_id", vin[0]);
        check_mem("stall2_mem", vexp[5]);
        check_flags("stall2_flags", vflg[5]);

        // Release: the stalled add result drains normally
        drive(vin[1], 1'b0, 1'b0);
        tick();
        check_id("unstall_id", vin[1]);
        check_mem("unstall_mem", vexp[0]);

        // Flush: ID/EX takes a bubble, EX/MEM still takes the multiply
        drive(vin[3], 1'b0, 1'b1);
        tick();
        check_id("flush_id", '0);
        check_mem("flush_mem_prev", vexp[1]);
        drive(vin[3], 1'b0, 1'b0);
        tick();
        check_id("after_flush_id", vin[3]);
        check_mem("flush_bubble_mem", '0);
        check_flags("flush_bubble_flags", 2'b10);

        // Stall and flush together: hold wins
        drive(vin[4], 1'b1, 1'b1);
        tick();
        check_id("stall_flush_id", vin[3]);
        check_mem("stall_flush_mem", '0);
        drive(vin[4], 1'b0, 1'b0);
        tick();
        check_id("post_sf_id", vin[4]);
        check_mem("post_sf_mem", vexp[3]);

        // Asynchronous reset mid-stream with both stages nonzero
        #2;
        rst_n = 1'b0;
        #1;
        check_id("async_rst_id", '0);
        check_mem("async_rst_mem", '0);
        check_flags("async_rst_flags", 2'b00);
        tick();
        check_id("async_hold_id", '0);
        check_mem("async_hold_mem", '0);
        #2;
        rst_n = 1'b1;
        drive(vin[6], 1'b0, 1'b0);
        tick();
        check_id("post_rst_id", vin[6]);
        check_mem("post_rst_mem", '0);
        tick();
        check_mem("post_rst_result", vexp[6]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ex_pipe_slice
